// File: rtl/noc_flit_ni.sv
// GPU-to-NoC network interface: TX/RX flit FIFOs, INIT->UP link FSM.
// Define NI_STATS_EN to add tx_flit_count/rx_flit_count outputs.
`timescale 1ns/1ps

module noc_flit_ni_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Storage is not reset; readers gate data with valid.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            unique case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rptr];
endmodule

module noc_flit_ni #(
    parameter int NODE_ID     = 32,
    parameter int TX_DEPTH    = 4,
    parameter int RX_DEPTH    = 4,
    parameter int INIT_CYCLES = 8,
    parameter int DROP_W      = 8
) (
    input  logic                          ACLK,
    input  logic                          ARESETn,
    input  logic [15:0]                   loc_data_in,
    input  logic                          loc_valid_in,
    output logic                          loc_ready_out,
    output logic [15:0]                   loc_data_out,
    output logic                          loc_valid_out,
    input  logic                          loc_ready_in,
    output logic [15:0]                   link_data_out,
    output logic                          link_valid_out,
    input  logic                          link_ready_in,
    input  logic [15:0]                   link_data_in,
    input  logic                          link_valid_in,
    output logic                          link_ready_out,
    output logic                          link_up,
    output logic [DROP_W-1:0]             drop_count,
    output logic [$clog2(TX_DEPTH):0]     tx_level,
    output logic [$clog2(RX_DEPTH):0]     rx_level
`ifdef NI_STATS_EN
    ,
    output logic [15:0]                   tx_flit_count,
    output logic [15:0]                   rx_flit_count
`endif
);
    localparam int TLW   = $clog2(TX_DEPTH) + 1;
    localparam int RLW   = $clog2(RX_DEPTH) + 1;
    localparam int CNT_W = $clog2(INIT_CYCLES + 1);
    localparam logic [5:0] MY_ID = 6'(NODE_ID);

    typedef enum logic {S_INIT, S_UP} state_t;

    state_t            state;
    state_t            state_nx;
    logic [CNT_W-1:0]  init_cnt;
    logic              up;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) state <= S_INIT;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_INIT: if (init_cnt == CNT_W'(INIT_CYCLES - 1)) state_nx = S_UP;
            S_UP:   state_nx = S_UP;
            default: state_nx = S_INIT;
        endcase
    end

    always_comb begin
        up = 1'b0;
        unique case (state)
            S_UP:    up = 1'b1;
            default: up = 1'b0;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)           init_cnt <= '0;
        else if (state == S_INIT) init_cnt <= init_cnt + CNT_W'(1);
    end

    assign link_up = up;

    logic        tx_push;
    logic        tx_pop;
    logic [15:0] tx_head;

    assign loc_ready_out  = up && (tx_level != TLW'(TX_DEPTH));
    assign link_valid_out = up && (tx_level != '0);
    assign tx_push        = loc_valid_in && loc_ready_out;
    assign tx_pop         = link_valid_out && link_ready_in;
    assign link_data_out  = link_valid_out ? tx_head : '0;

    noc_flit_ni_fifo #(.DEPTH(TX_DEPTH), .W(16)) u_tx_fifo (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .push  (tx_push),
        .wdata (loc_data_in),
        .pop   (tx_pop),
        .rdata (tx_head),
        .level (tx_level)
    );

    logic        link_xfer;
    logic        rx_hit;
    logic        rx_push;
    logic        rx_pop;
    logic [15:0] rx_head;

    // Ready ignores the address so misrouted flits are always drained.
    assign link_ready_out = up && (rx_level != RLW'(RX_DEPTH));
    assign link_xfer      = link_valid_in && link_ready_out;
    assign rx_hit         = (link_data_in[15:10] == MY_ID);
    assign rx_push        = link_xfer && rx_hit;
    assign loc_valid_out  = up && (rx_level != '0);
    assign rx_pop         = loc_valid_out && loc_ready_in;
    assign loc_data_out   = loc_valid_out ? rx_head : '0;

    noc_flit_ni_fifo #(.DEPTH(RX_DEPTH), .W(16)) u_rx_fifo (
        .clk   (ACLK),
        .rst_n (ARESETn),
        .push  (rx_push),
        .wdata (link_data_in),
        .pop   (rx_pop),
        .rdata (rx_head),
        .level (rx_level)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn)
            drop_count <= '0;
        else if (link_xfer && !rx_hit && (drop_count != '1))
            drop_count <= drop_count + DROP_W'(1);
    end

`ifdef NI_STATS_EN
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            tx_flit_count <= '0;
            rx_flit_count <= '0;
        end else begin
            if (tx_pop)  tx_flit_count <= tx_flit_count + 16'd1;
            if (rx_push) rx_flit_count <= rx_flit_count + 16'd1;
        end
    end
`endif
endmodule

// File: doc/noc_flit_ni.md
Name: noc_flit_ni

Overview:
- Network-interface endpoint between one GPU's 16-bit flit port and its NoC router link.
- TX path buffers flits issued by the GPU and drives them onto the router link.
- RX path accepts flits from the link, keeps those addressed to NODE_ID, and delivers them to the GPU.
- Flit format: [15:10] destination node ID, [9:0] payload. All interfaces use valid/ready.

Parameters:
- NODE_ID, 32: node ID this NI accepts on RX (compared against flit[15:10]).
- TX_DEPTH, 4: TX FIFO entries; power of two, >=2.
- RX_DEPTH, 4: RX FIFO entries; power of two, >=2.
- INIT_CYCLES, 8: cycles spent in INIT after reset before the link comes up; >=1.
- DROP_W, 8: width of the misaddressed-flit drop counter.

Ports:
- ACLK  in  1  clock, rising edge
- ARESETn  in  1  asynchronous active-low reset
- loc_data_in  in  16  flit from GPU (GPU TX)
- loc_valid_in  in  1  loc_data_in valid
- loc_ready_out  out  1  NI can accept a GPU flit
- loc_data_out  out  16  flit to GPU (GPU RX)
- loc_valid_out  out  1  loc_data_out valid
- loc_ready_in  in  1  GPU accepts flit
- link_data_out  out  16  flit to router
- link_valid_out  out  1  link_data_out valid
- link_ready_in  in  1  router accepts flit
- link_data_in  in  16  flit from router
- link_valid_in  in  1  link_data_in valid
- link_ready_out  out  1  NI can accept a router flit
- link_up  out  1  link state is UP
- drop_count  out  DROP_W  saturating count of misaddressed RX flits
- tx_level  out  $clog2(TX_DEPTH)+1  TX FIFO occupancy
- rx_level  out  $clog2(RX_DEPTH)+1  RX FIFO occupancy

Behaviour:
- Clock and reset: single clock ACLK. ARESETn is asynchronous, active-low. All outputs are 0 in reset.
- Reset contents: FIFOs empty, drop_count=0, state=INIT, init counter=0.
- Reset mid-operation: all buffered flits are discarded and nothing is emitted afterwards.
- Link FSM, INIT -> UP:
  - INIT: counter increments each cycle. Both ready outputs and both valid outputs are held 0.
  - INIT exits to UP when counter == INIT_CYCLES-1.
  - UP: terminal state; link_up=1.
- Handshake rules:
  - A transfer occurs on any cycle with valid && ready.
  - The source holds data stable while valid && !ready.
  - The NI never deasserts an asserted valid before the transfer completes.
- TX path:
  - loc_ready_out = UP && tx_level<TX_DEPTH.
  - On a local transfer the full 16-bit flit is pushed unchanged. There is no destination filtering on TX.
  - link_valid_out = UP && tx_level!=0; link_data_out = FIFO head.
  - Pop on link transfer.
- RX path:
  - link_ready_out = UP && rx_level<RX_DEPTH. This holds regardless of the incoming flit's address.
  - On a link transfer with flit[15:10]==NODE_ID[5:0], push the flit.
  - On a link transfer with any other destination, discard the flit and increment drop_count, saturating at all-ones.
  - loc_valid_out = UP && rx_level!=0; loc_data_out = FIFO head.
  - Pop on local transfer.
- Latency:
  - Push into an empty FIFO: valid is visible on the output the next cycle (1 cycle). There is no same-cycle bypass.
  - Throughput is 1 flit/cycle per path.
- Simultaneous events:
  - Push and pop in the same cycle: level is unchanged and order is preserved.
  - At full, ready is low, so no push. At empty, valid is low, so no pop.
- Pointers and levels:
  - Pointers wrap modulo depth.
  - Level counters are exact, 0..DEPTH inclusive.
- Independence: TX and RX paths are fully independent; a TX stall never blocks RX, and vice versa.

Optional Feature:
- Macro: NI_STATS_EN.
- When defined:
  - Adds outputs tx_flit_count[15:0] and rx_flit_count[15:0], reset to 0.
  - tx_flit_count increments on each link-side TX transfer.
  - rx_flit_count increments on each accepted (pushed) RX flit.
  - Both wrap at 16 bits.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Init: release reset, hold all valids 1 -> ready/valid outputs stay 0 for exactly 8 cycles, then link_up=1 and loc_ready_out=1, link_ready_out=1.
- TX single flit: loc_data_in=16'h8523 (dest 33, payload 0x123) with link_ready_in=1 -> link_valid_out=1 with link_data_out=16'h8523 one cycle after the transfer, tx_level returns to 0.
- TX backpressure: link_ready_in=0, push 5 flits 16'h0001..0005 -> loc_ready_out drops after 4 accepted, tx_level=4. Raise link_ready_in -> 0001..0004 emitted in order, then 0005 accepted.
- RX filtering: link flits 16'h8123 (dest 32), 16'h8523 (dest 33), 16'h8124 -> GPU receives 8123 then 8124, drop_count=1.
- RX full plus simultaneous push/pop:
  - loc_ready_in=0, send 4 flits addressed to 32 -> link_ready_out=0, rx_level=4.
  - Then loc_ready_in=1 -> one pop per cycle; with continuous link input, rx_level stays constant.
- Reset mid-stream: assert ARESETn=0 with tx_level=3 -> all outputs 0 immediately. After release, the INIT sequence repeats and no stale flit appears on link_data_out.
